irq_gateway_array: RTL and testbench

//  N-channel interrupt gateway; parametrised successor to the 1-bit signal pass-throughs at the core boundary.

---
 rtl/irq_gateway_array_if.sv | 25 ++
 rtl/irq_gateway_array.sv | 109 ++++++++++
 tb/tb_irq_gateway_array.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_gateway_array_if.sv
// Request/claim/complete bundle between platform interrupt wires, the gateway and the core interrupt controller.
// The master side drives the lines and service strobes; the gateway is the slave.
interface irq_gateway_array_if #(
    parameter int N_CH = 8,
    parameter int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH-1:0] irq_in;
    logic [N_CH-1:0] irq_en;
    logic [N_CH-1:0] pending;
    logic            req_valid;
    logic [ID_W-1:0] req_id;
    logic            claim;
    logic            complete_valid;
    logic [ID_W-1:0] complete_id;

    modport master (
        output irq_in, irq_en, claim, complete_valid, complete_id,
        input  pending, req_valid, req_id
    );

    modport slave (
        input  irq_in, irq_en, claim, complete_valid, complete_id,
        output pending, req_valid, req_id
    );
endinterface

// File: rtl/irq_gateway_array.sv
// N-channel interrupt gateway: synchronise, trigger by level/edge, hold one request per channel,
// arbitrate lowest index first and block each channel until its completion arrives.
module irq_gateway_array #(
    parameter int              N_CH        = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] EDGE_MASK   = '0
) (
    input logic            clock,
    input logic            reset,
    irq_gateway_array_if.slave bus
);
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_IN_SERVICE
    } ch_state_t;

    logic [N_CH-1:0] s;
    logic [N_CH-1:0] hist_reg;
    logic [N_CH-1:0] trig;
    logic [N_CH-1:0] pending_vec;
    logic [N_CH-1:0] active;
    logic            req_valid;
    logic [ID_W-1:0] req_id;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = bus.irq_in;
    end else begin : g_sync
        logic [N_CH-1:0] sync_reg [SYNC_STAGES];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
            end else begin
                sync_reg[0] <= bus.irq_in;
                for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
            end
        end

        assign s = sync_reg[SYNC_STAGES-1];
    end

    always_ff @(posedge clock) begin
        if (reset) hist_reg <= '0;
        else       hist_reg <= s;
    end

    // History clears on reset, so an edge line already high afterwards still fires once.
    assign trig = s & ~(EDGE_MASK & hist_reg);

    assign active = pending_vec & bus.irq_en;

    always_comb begin
        req_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (active[i]) req_id = ID_W'(i);
        end
    end

    assign req_valid = |active;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam bit IS_EDGE = EDGE_MASK[gi];

        ch_state_t state_reg;
        logic      missed_reg;
        logic      claim_hit;
        logic      complete_hit;

        assign claim_hit    = bus.claim & req_valid & (req_id == ID_W'(gi));
        // Ids at or beyond N_CH never match any channel, so such completes fall through.
        assign complete_hit = bus.complete_valid & (bus.complete_id == ID_W'(gi));

        always_ff @(posedge clock) begin
            if (reset) begin
                state_reg  <= ST_IDLE;
                missed_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (trig[gi]) state_reg <= ST_PENDING;
                    end
                    ST_PENDING: begin
                        if (IS_EDGE && trig[gi]) missed_reg <= 1'b1;
                        if (claim_hit)           state_reg  <= ST_IN_SERVICE;
                    end
                    ST_IN_SERVICE: begin
                        // An edge landing on the completing cycle counts as missed and re-arms.
                        if (complete_hit) begin
                            state_reg  <= (IS_EDGE && (missed_reg || trig[gi])) ? ST_PENDING : ST_IDLE;
                            missed_reg <= 1'b0;
                        end else if (IS_EDGE && trig[gi]) begin
                            missed_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end

        assign pending_vec[gi] = (state_reg == ST_PENDING);
    end

    assign bus.pending   = pending_vec;
    assign bus.req_valid = req_valid;
    assign bus.req_id    = req_id;
endmodule

// File: tb/tb_irq_gateway_array.sv
// Bench for irq_gateway_array: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against a behavioural channel model.
module tb_irq_gateway_array;
    localparam int          N_CH = 8;
    localparam int          SYNC = 2;
    localparam int          ID_W = 3;
    localparam logic [7:0]  EM   = 8'h44;   // channels 2 and 6 edge-triggered

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    irq_gateway_array_if #(.N_CH(N_CH)) bus ();

    irq_gateway_array #(
        .N_CH(N_CH),
        .SYNC_STAGES(SYNC),
        .EDGE_MASK(EM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Model: 0 = idle, 1 = pending, 2 = in service
    int              m_state  [N_CH];
    bit              m_missed [N_CH];
    logic [N_CH-1:0] m_line_hist [4];   // m_line_hist[k] = irq_in sampled k+1 edges ago
    logic [N_CH-1:0] m_prev;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pending();
        int v = 0;
        for (int i = 0; i < N_CH; i++) if (m_state[i] == 1) v |= (1 << i);
        return v;
    endfunction

    function automatic int m_req_id();
        for (int i = 0; i < N_CH; i++)
            if (m_state[i] == 1 && bus.irq_en[i]) return i;
        return 0;
    endfunction

    function automatic bit m_req_valid();
        for (int i = 0; i < N_CH; i++)
            if (m_state[i] == 1 && bus.irq_en[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [N_CH-1:0] s;
        bit trig;
        bit edge_ch;
        int claim_ch;
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                m_state[i]  = 0;
                m_missed[i] = 1'b0;
            end
            for (int k = 0; k < 4; k++) m_line_hist[k] = '0;
            m_prev = '0;
            return;
        end
        s = (SYNC == 0) ? bus.irq_in : m_line_hist[SYNC-1];
        claim_ch = (bus.claim && m_req_valid()) ? m_req_id() : -1;
        for (int i = 0; i < N_CH; i++) begin
            edge_ch = EM[i];
            trig    = edge_ch ? (s[i] && !m_prev[i]) : s[i];
            if (m_state[i] == 0) begin
                if (trig) m_state[i] = 1;
            end else if (m_state[i] == 1) begin
                if (edge_ch && trig) m_missed[i] = 1'b1;
                if (i == claim_ch) m_state[i] = 2;
            end else begin
                if (bus.complete_valid && int'(bus.complete_id) == i) begin
                    m_state[i]  = (edge_ch && (m_missed[i] || trig)) ? 1 : 0;
                    m_missed[i] = 1'b0;
                end else if (edge_ch && trig) begin
                    m_missed[i] = 1'b1;
                end
            end
        end
        m_prev = s;
        for (int k = 3; k > 0; k--) m_line_hist[k] = m_line_hist[k-1];
        m_line_hist[0] = bus.irq_in;
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pulse_claim();
        bus.claim = 1'b1;
        tick(1);
        bus.claim = 1'b0;
    endtask

    task automatic complete(int id);
        bus.complete_valid = 1'b1;
        bus.complete_id    = ID_W'(id);
        tick(1);
        bus.complete_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            check("pending_vs_model",   int'(bus.pending),   m_pending());
            check("req_valid_vs_model", int'(bus.req_valid), int'(m_req_valid()));
            check("req_id_vs_model",    int'(bus.req_id),    m_req_id());
        end
    end

    initial begin
        logic [31:0] r;
        reset              = 1'b1;
        bus.irq_in         = '0;
        bus.irq_en         = '1;
        bus.claim          = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_id    = '0;
        tick(3);
        chk_on = 1'b1;
        check("reset_pending",   int'(bus.pending),   0);
        check("reset_req_valid", int'(bus.req_valid), 0);
        check("reset_req_id",    int'(bus.req_id),    0);

        // Level ch3: raised before edge 0, pending after edge 2
        reset         = 1'b0;
        bus.irq_in[3] = 1'b1;
        tick(2);
        check("lvl3_not_yet", int'(bus.pending), 'h00);
        tick(1);
        check("lvl3_pending", int'(bus.pending), 'h08);
        check("lvl3_req_valid", int'(bus.req_valid), 1);
        check("lvl3_req_id", int'(bus.req_id), 3);
        bus.irq_in[3] = 1'b0;
        tick(4);
        check("lvl3_latched", int'(bus.pending), 'h08);
        pulse_claim();
        check("lvl3_claimed", int'(bus.pending), 'h00);
        complete(3);
        $display("txn: level ch3 raise/claim/complete");

        // ch1 and ch5 arbitration
        bus.irq_in = 8'h22;
        tick(3);
        check("arb_pending", int'(bus.pending), 'h22);
        check("arb_id1", int'(bus.req_id), 1);
        bus.irq_in = '0;
        pulse_claim();
        check("arb_after_claim", int'(bus.pending), 'h20);
        check("arb_id5", int'(bus.req_id), 5);
        bus.irq_en[5] = 1'b0;
        #1;
        check("arb_en5_off", int'(bus.req_valid), 0);
        bus.irq_en = '1;
        #1;
        pulse_claim();
        complete(1);
        complete(5);
        check("arb_all_done", int'(bus.pending), 'h00);
        $display("txn: arbitration ch1/ch5");

        // Edge ch2 with two missed pulses while in service
        bus.irq_in[2] = 1'b1;
        tick(1);
        bus.irq_in[2] = 1'b0;
        tick(2);
        check("edge2_pending", int'(bus.pending), 'h04);
        pulse_claim();
        check("edge2_claimed", int'(bus.pending), 'h00);
        repeat (2) begin
            bus.irq_in[2] = 1'b1;
            tick(1);
            bus.irq_in[2] = 1'b0;
            tick(2);
        end
        tick(2);
        check("edge2_in_service", int'(bus.pending), 'h00);
        complete(2);
        check("edge2_repend", int'(bus.pending), 'h04);
        pulse_claim();
        complete(2);
        check("edge2_idle", int'(bus.pending), 'h00);
        tick(3);
        check("edge2_stays_idle", int'(bus.pending), 'h00);
        $display("txn: edge ch2 missed-edge merge");

        // Stray completes leave state alone
        bus.irq_in[3] = 1'b1;
        tick(3);
        bus.irq_in[3] = 1'b0;
        complete(4);
        complete(3);
        check("stray_pending", int'(bus.pending), 'h08);
        check("stray_req_id", int'(bus.req_id), 3);
        pulse_claim();
        complete(3);
        tick(2);
        $display("txn: stray completes ignored");

        // Level ch0 held high through completion
        bus.irq_in[0] = 1'b1;
        tick(3);
        check("lvl0_pending", int'(bus.pending), 'h01);
        pulse_claim();
        check("lvl0_in_service", int'(bus.pending), 'h00);
        complete(0);
        check("lvl0_idle_gap", int'(bus.pending), 'h00);
        tick(1);
        check("lvl0_repend", int'(bus.pending), 'h01);
        bus.irq_in[0] = 1'b0;
        pulse_claim();
        complete(0);
        tick(3);
        $display("txn: level ch0 held through complete");

        // Reset with ch6 in service and ch7 pending
        bus.irq_in[6] = 1'b1;
        tick(1);
        bus.irq_in[6] = 1'b0;
        tick(2);
        check("rst_ch6_pending", int'(bus.pending), 'h40);
        pulse_claim();
        bus.irq_in[7] = 1'b1;
        tick(3);
        check("rst_ch7_pending", int'(bus.pending), 'h80);
        reset         = 1'b1;
        bus.irq_in[7] = 1'b0;
        tick(1);
        reset = 1'b0;
        check("rst_pending", int'(bus.pending), 'h00);
        check("rst_req_valid", int'(bus.req_valid), 0);
        complete(6);
        tick(3);
        check("rst_complete6_ignored", int'(bus.pending), 'h00);
        $display("txn: reset mid-service");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom & $urandom & $urandom;
            bus.irq_in         = bus.irq_in ^ r[7:0];
            bus.irq_en         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            bus.claim          = ($urandom_range(0, 2) == 0);
            bus.complete_valid = ($urandom_range(0, 2) == 0);
            bus.complete_id    = ID_W'($urandom_range(0, N_CH - 1));
            reset              = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset              = 1'b0;
        bus.claim          = 1'b0;
        bus.complete_valid = 1'b0;
        tick(2);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
